// File: rtl/my_bitscan16_if.sv
// Handshake bundle for my_bitscan16: word input channel and per-index output channel.
// The producer/consumer side uses the master modport; the scanner uses slave.
interface my_bitscan16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_last
    );
endinterface

// File: rtl/my_bitscan16.sv
// Serial set-bit scanner: takes a 16-bit mask and emits the index of each set bit, flagging the last.
// Define MY_BITSCAN16_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
//
// state | meaning
// IDLE  | ready for a word; mask is empty
// SCAN  | presenting the priority bit of a non-empty mask
module my_bitscan16 (
    input  logic           clk,
    input  logic           rst_n,
    my_bitscan16_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t      state, state_next;
    logic [15:0] mask, mask_next;
    logic [3:0]  index;
    logic        last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            mask  <= '0;
        end else begin
            state <= state_next;
            mask  <= mask_next;
        end
    end

    // The final assignment in loop order wins, so the loop direction sets the priority.
    always_comb begin
        index = '0;
`ifdef MY_BITSCAN16_MSB_FIRST_EN
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) index = 4'(i);
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) index = 4'(i);
        end
`endif
    end

    // Exactly one bit set; the mask is empty in IDLE, so both outputs read 0 there.
    assign last = (mask != 16'h0000) && ((mask & (mask - 16'h0001)) == 16'h0000);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == SCAN);
    assign bus.out_index = index;
    assign bus.out_last  = last;

    always_comb begin
        state_next = state;
        mask_next  = mask;
        case (state)
            IDLE: begin
                if (bus.in_valid && (bus.in_data != 16'h0000)) begin
                    mask_next  = bus.in_data;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    mask_next = mask & ~(16'h0001 << index);
                    if (last) state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_my_bitscan16.sv
// Directed bench for my_bitscan16; expected beat order follows MY_BITSCAN16_MSB_FIRST_EN.
module tb_my_bitscan16;

`ifdef MY_BITSCAN16_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    my_bitscan16_if bus ();

    my_bitscan16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ord(input int i, input int lo, input int hi);
        return MSB ? 4'(hi - i) : 4'(lo + i);
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h00FF;
        bus.out_ready = 1'b0;

        // reset holds off a pending word
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_in_ready", 16'(bus.in_ready), 16'h1);
            chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
            chk("rst_out_index", 16'(bus.out_index), 16'h0);
            chk("rst_out_last", 16'(bus.out_last), 16'h0);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("post_rst_out_valid", 16'(bus.out_valid), 16'h0);
        end

        // 0x8001 with out_ready held high
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h8001;
        bus.out_ready = 1'b1;
        chk("w8001_in_ready_pre", 16'(bus.in_ready), 16'h1);
        tick();
        bus.in_valid = 1'b0;
        chk("w8001_b0_valid", 16'(bus.out_valid), 16'h1);
        chk("w8001_b0_in_ready", 16'(bus.in_ready), 16'h0);
        chk("w8001_b0_index", 16'(bus.out_index), MSB ? 16'd15 : 16'd0);
        chk("w8001_b0_last", 16'(bus.out_last), 16'h0);
        tick();
        chk("w8001_b1_valid", 16'(bus.out_valid), 16'h1);
        chk("w8001_b1_in_ready", 16'(bus.in_ready), 16'h0);
        chk("w8001_b1_index", 16'(bus.out_index), MSB ? 16'd0 : 16'd15);
        chk("w8001_b1_last", 16'(bus.out_last), 16'h1);
        tick();
        chk("w8001_done_valid", 16'(bus.out_valid), 16'h0);
        chk("w8001_done_in_ready", 16'(bus.in_ready), 16'h1);

        // 0xFFFF with alternating out_ready; in_data changes mid-scan must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h1234;
        for (int i = 0; i < 16; i++) begin
            bus.out_ready = 1'b0;
            chk("wffff_valid", 16'(bus.out_valid), 16'h1);
            chk("wffff_index", 16'(bus.out_index), 16'(ord(i, 0, 15)));
            chk("wffff_last", 16'(bus.out_last), (i == 15) ? 16'h1 : 16'h0);
            tick();
            chk("wffff_stall_index", 16'(bus.out_index), 16'(ord(i, 0, 15)));
            chk("wffff_stall_last", 16'(bus.out_last), (i == 15) ? 16'h1 : 16'h0);
            bus.out_ready = 1'b1;
            tick();
        end
        chk("wffff_done_valid", 16'(bus.out_valid), 16'h0);
        chk("wffff_done_in_ready", 16'(bus.in_ready), 16'h1);

        // zero word then 0x0004 back to back
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0000;
        tick();
        chk("zero_out_valid", 16'(bus.out_valid), 16'h0);
        chk("zero_in_ready", 16'(bus.in_ready), 16'h1);
        bus.in_data = 16'h0004;
        tick();
        bus.in_valid = 1'b0;
        chk("w0004_valid", 16'(bus.out_valid), 16'h1);
        chk("w0004_index", 16'(bus.out_index), 16'd2);
        chk("w0004_last", 16'(bus.out_last), 16'h1);
        tick();
        chk("w0004_done_valid", 16'(bus.out_valid), 16'h0);

        // 0x00F0 with reset after two beats
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00F0;
        tick();
        bus.in_valid = 1'b0;
        chk("w00f0_b0_index", 16'(bus.out_index), 16'(ord(0, 4, 7)));
        chk("w00f0_b0_last", 16'(bus.out_last), 16'h0);
        tick();
        chk("w00f0_b1_index", 16'(bus.out_index), 16'(ord(1, 4, 7)));
        tick();
        chk("w00f0_b2_valid", 16'(bus.out_valid), 16'h1);
        rst_n = 1'b0;
        tick();
        chk("w00f0_rst_valid", 16'(bus.out_valid), 16'h0);
        chk("w00f0_rst_in_ready", 16'(bus.in_ready), 16'h1);
        chk("w00f0_rst_index", 16'(bus.out_index), 16'h0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("w00f0_after_valid", 16'(bus.out_valid), 16'h0);
        chk("w00f0_after_last", 16'(bus.out_last), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
